// File: rtl/vga_pkg.sv
// Shared VGA timing constants, coordinate and region types.
// Imported by the raster generator and the region/colour logic.
package vga_pkg;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;
  localparam int DEF_CLK_DIV   = 2;

  localparam int H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT
                         + DEF_H_SYNC + DEF_H_BACK;
  localparam int V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT
                         + DEF_V_SYNC + DEF_V_BACK;

  typedef logic [9:0] coord_t;

  typedef enum logic [1:0] {
    RGN_NONE,
    RGN_SKY,
    RGN_HUD,
    RGN_FIELD
  } region_t;

  function automatic logic inWindow(
    input coord_t v,
    input coord_t lo,
    input coord_t hi
  );
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen_clk_en_div.sv
// Clock-enable divider: ce is high one Clk cycle in every CLK_DIV.
// ce decodes the counter so it is available in the same cycle.
module clk_en_div #(
  parameter int CLK_DIV = 2
) (
  input  logic Clk,
  input  logic Reset,
  output logic ce
);

  localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

  logic [W-1:0] div;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      div <= '0;
    end else if (div == LAST) begin
      div <= '0;
    end else begin
      div <= div + W'(1);
    end
  end

  assign ce = (div == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing driven by a pixel clock-enable.
// Sync/blank are registered from next-state counters to stay aligned.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK,
  parameter int CLK_DIV   = DEF_CLK_DIV
) (
  input  logic       Clk,
  input  logic       Reset,
  output logic       pixel_ce,
  output coord_t     DrawX,
  output coord_t     DrawY,
  output logic       hs,
  output logic       vs,
  output logic       blank_n,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int HT = H_VISIBLE + H_FRONT
                    + H_SYNC + H_BACK;
  localparam int VT = V_VISIBLE + V_FRONT
                    + V_SYNC + V_BACK;

  localparam coord_t H_LAST = coord_t'(HT - 1);
  localparam coord_t V_LAST = coord_t'(VT - 1);
  localparam coord_t H_VIS  = coord_t'(H_VISIBLE);
  localparam coord_t V_VIS  = coord_t'(V_VISIBLE);
  localparam coord_t HS_BEG = coord_t'(H_VISIBLE + H_FRONT);
  localparam coord_t HS_END = coord_t'(H_VISIBLE + H_FRONT
                                       + H_SYNC - 1);
  localparam coord_t VS_BEG = coord_t'(V_VISIBLE + V_FRONT);
  localparam coord_t VS_END = coord_t'(V_VISIBLE + V_FRONT
                                       + V_SYNC - 1);

  coord_t nextX;
  coord_t nextY;
  logic   lineWrap;

  clk_en_div #(
    .CLK_DIV(CLK_DIV)
  ) u_div (
    .Clk  (Clk),
    .Reset(Reset),
    .ce   (pixel_ce)
  );

  always_comb begin
    lineWrap = (DrawX == H_LAST);
    nextX    = lineWrap ? '0 : DrawX + coord_t'(1);
    nextY    = DrawY;
    if (lineWrap) begin
      nextY = (DrawY == V_LAST) ? '0 : DrawY + coord_t'(1);
    end
  end

  // Reset parks the raster on the last pixel so the first ce lands on (0,0)
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      DrawX       <= H_LAST;
      DrawY       <= V_LAST;
      hs          <= 1'b1;
      vs          <= 1'b1;
      blank_n     <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (pixel_ce) begin
        DrawX       <= nextX;
        DrawY       <= nextY;
        hs          <= !inWindow(nextX, HS_BEG, HS_END);
        vs          <= !inWindow(nextY, VS_BEG, VS_END);
        blank_n     <= (nextX < H_VIS) && (nextY < V_VIS);
        line_start  <= (nextX == '0);
        frame_start <= (nextX == '0) && (nextY == '0);
        if (lineWrap && (nextY == VS_BEG)) begin
          frame_count <= frame_count + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: closed-form raster model, vector table,
// period checks, frame_count wrap and async mid-frame resets.
module tb_vga_timing_gen;
  import vga_pkg::*;

  typedef struct {
    int hv, hf, hsw, hb;
    int vv, vf, vsw, vb;
    int d;
  } cfg_t;

  typedef struct packed {
    logic       ce;
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       bl;
    logic       ls;
    logic       fs;
    logic [7:0] fc;
  } exp_t;

  typedef struct {
    int         k;
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       bl;
    logic       ls;
    logic       fs;
  } vec_t;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  cfg_t c0 = '{640, 16, 96, 48, 480, 10, 2, 33, 2};
  cfg_t c1 = '{8, 2, 2, 2, 6, 2, 2, 2, 1};
  cfg_t c2 = '{10, 3, 4, 3, 8, 2, 3, 2, 3};
  cfg_t c3 = '{640, 16, 96, 48, 480, 10, 2, 33, 1};

  logic rst0 = 1'b1, rst1 = 1'b1, rst2 = 1'b1, rst3 = 1'b1;
  logic ce0, ce1, ce2, ce3;
  logic [9:0] dx0, dx1, dx2, dx3, dy0, dy1, dy2, dy3;
  logic hs0, hs1, hs2, hs3, vs0, vs1, vs2, vs3;
  logic bl0, bl1, bl2, bl3, ls0, ls1, ls2, ls3;
  logic fs0, fs1, fs2, fs3;
  logic [7:0] fc0, fc1, fc2, fc3;

  vga_timing_gen u0 (
    .Clk(Clk), .Reset(rst0), .pixel_ce(ce0),
    .DrawX(dx0), .DrawY(dy0), .hs(hs0), .vs(vs0),
    .blank_n(bl0), .line_start(ls0),
    .frame_start(fs0), .frame_count(fc0)
  );

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2),
    .CLK_DIV(1)
  ) u1 (
    .Clk(Clk), .Reset(rst1), .pixel_ce(ce1),
    .DrawX(dx1), .DrawY(dy1), .hs(hs1), .vs(vs1),
    .blank_n(bl1), .line_start(ls1),
    .frame_start(fs1), .frame_count(fc1)
  );

  vga_timing_gen #(
    .H_VISIBLE(10), .H_FRONT(3), .H_SYNC(4), .H_BACK(3),
    .V_VISIBLE(8), .V_FRONT(2), .V_SYNC(3), .V_BACK(2),
    .CLK_DIV(3)
  ) u2 (
    .Clk(Clk), .Reset(rst2), .pixel_ce(ce2),
    .DrawX(dx2), .DrawY(dy2), .hs(hs2), .vs(vs2),
    .blank_n(bl2), .line_start(ls2),
    .frame_start(fs2), .frame_count(fc2)
  );

  vga_timing_gen #(
    .CLK_DIV(1)
  ) u3 (
    .Clk(Clk), .Reset(rst3), .pixel_ce(ce3),
    .DrawX(dx3), .DrawY(dy3), .hs(hs3), .vs(vs3),
    .blank_n(bl3), .line_start(ls3),
    .frame_start(fs3), .frame_count(fc3)
  );

  // Clk edges seen since each reset was last released.
  int k0 = 0, k1 = 0, k2 = 0, k3 = 0;
  always @(posedge Clk or posedge rst0) k0 <= rst0 ? 0 : k0 + 1;
  always @(posedge Clk or posedge rst1) k1 <= rst1 ? 0 : k1 + 1;
  always @(posedge Clk or posedge rst2) k2 <= rst2 ? 0 : k2 + 1;
  always @(posedge Clk or posedge rst3) k3 <= rst3 ? 0 : k3 + 1;

  // Expected outputs after k edges, from raster arithmetic alone.
  function automatic exp_t model(input cfg_t c, input int k);
    exp_t e;
    int ht, vt, tot, p, lin, x, y, t, hsb, vsb;
    bit stepped;
    ht  = c.hv + c.hf + c.hsw + c.hb;
    vt  = c.vv + c.vf + c.vsw + c.vb;
    tot = ht * vt;
    p   = k / c.d;
    lin = (p == 0) ? tot - 1 : (p - 1) % tot;
    x   = lin % ht;
    y   = lin / ht;
    hsb = c.hv + c.hf;
    vsb = c.vv + c.vf;
    t   = vsb * ht;
    stepped = (k >= 1) && (k % c.d == 0);
    e.ce = (k % c.d == c.d - 1);
    e.x  = 10'(x);
    e.y  = 10'(y);
    e.hs = !(x >= hsb && x <= hsb + c.hsw - 1);
    e.vs = !(y >= vsb && y <= vsb + c.vsw - 1);
    e.bl = (x < c.hv) && (y < c.vv);
    e.ls = stepped && (x == 0);
    e.fs = stepped && (x == 0) && (y == 0);
    e.fc = (p >= 1 && p - 1 >= t) ?
           8'(((p - 1 - t) / tot + 1) % 256) : 8'd0;
    return e;
  endfunction

  task automatic chk(input string nm, input int k,
                     input exp_t g, input exp_t e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s k=%0d got ce=%0b x=%0d y=%0d hs=%0b vs=%0b bl=%0b ls=%0b fs=%0b fc=%0d exp ce=%0b x=%0d y=%0d hs=%0b vs=%0b bl=%0b ls=%0b fs=%0b fc=%0d",
        nm, k, g.ce, g.x, g.y, g.hs, g.vs, g.bl, g.ls, g.fs, g.fc,
        e.ce, e.x, e.y, e.hs, e.vs, e.bl, e.ls, e.fs, e.fc);
    end
  endtask

  task automatic chkInt(input string nm, input int g, input int e);
    checks++;
    if (g != e) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", nm, g, e);
    end
  endtask

  always @(negedge Clk) begin
    chk("u0", k0, {ce0, dx0, dy0, hs0, vs0, bl0, ls0, fs0, fc0},
        model(c0, k0));
    chk("u1", k1, {ce1, dx1, dy1, hs1, vs1, bl1, ls1, fs1, fc1},
        model(c1, k1));
    chk("u2", k2, {ce2, dx2, dy2, hs2, vs2, bl2, ls2, fs2, fc2},
        model(c2, k2));
    chk("u3", k3, {ce3, dx3, dy3, hs3, vs3, bl3, ls3, fs3, fc3},
        model(c3, k3));
  end

  int lastLs0 = -1, lastLs3 = -1, lastFs1 = -1;
  int hsRun0 = 0, vsRun1 = 0;

  always @(negedge Clk) begin
    if (rst0) begin
      lastLs0 <= -1;
      hsRun0  <= 0;
    end else begin
      if (ls0) begin
        if (lastLs0 >= 0) chkInt("u0 linePeriod", k0 - lastLs0, 1600);
        lastLs0 <= k0;
      end
      if (!hs0) hsRun0 <= hsRun0 + 1;
      else if (hsRun0 != 0) begin
        chkInt("u0 hsLen", hsRun0, 192);
        hsRun0 <= 0;
      end
    end
    if (!rst3 && ls3) begin
      if (lastLs3 >= 0) chkInt("u3 linePeriod", k3 - lastLs3, 800);
      lastLs3 <= k3;
    end
    if (rst1) begin
      lastFs1 <= -1;
      vsRun1  <= 0;
    end else begin
      if (fs1) begin
        if (lastFs1 >= 0) chkInt("u1 framePeriod", k1 - lastFs1, 168);
        lastFs1 <= k1;
      end
      if (!vs1) vsRun1 <= vsRun1 + 1;
      else if (vsRun1 != 0) begin
        chkInt("u1 vsLen", vsRun1, 28);
        vsRun1 <= 0;
      end
    end
  end

  vec_t vecs[12];

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{0,    10'd799, 10'd524, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1,    10'd799, 10'd524, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{2,    10'd0,   10'd0,   1'b1, 1'b1, 1'b1, 1'b1};
    vecs[3]  = '{3,    10'd0,   10'd0,   1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1280, 10'd639, 10'd0,   1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1282, 10'd640, 10'd0,   1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1313, 10'd655, 10'd0,   1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1314, 10'd656, 10'd0,   1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1504, 10'd751, 10'd0,   1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1506, 10'd752, 10'd0,   1'b1, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1602, 10'd0,   10'd1,   1'b1, 1'b1, 1'b1, 1'b0};
    vecs[11] = '{1603, 10'd0,   10'd1,   1'b1, 1'b1, 1'b0, 1'b0};

    repeat (3) @(posedge Clk);
    #1;
    rst0 = 1'b0;
    rst1 = 1'b0;
    rst2 = 1'b0;
    rst3 = 1'b0;

    fork
      begin : tableSeq
        for (int i = 0; i < 12; i++) begin
          for (int n = 0; n < 5000 && k0 < vecs[i].k; n++)
            @(negedge Clk);
          if (k0 != vecs[i].k) begin
            chkInt("u0 vecTimeout", k0, vecs[i].k);
          end else begin
            checks++;
            if ({dx0, dy0, hs0, vs0, bl0, ls0, fs0} !==
                {vecs[i].x, vecs[i].y, vecs[i].hs, 1'b1,
                 vecs[i].bl, vecs[i].ls, vecs[i].fs}) begin
              errors++;
              $display("FAIL vec%0d got x=%0d y=%0d hs=%0b vs=%0b bl=%0b ls=%0b fs=%0b exp x=%0d y=%0d hs=%0b vs=1 bl=%0b ls=%0b fs=%0b",
                i, dx0, dy0, hs0, vs0, bl0, ls0, fs0, vecs[i].x,
                vecs[i].y, vecs[i].hs, vecs[i].bl, vecs[i].ls,
                vecs[i].fs);
            end
          end
        end
      end
      begin : resetSeq
        int n;
        for (n = 0; n < 1000 && k2 < 198; n++) @(posedge Clk);
        #1;
        chkInt("u2 preResetX", int'(dx2), 5);
        chkInt("u2 preResetY", int'(dy2), 3);
        rst2 = 1'b1;
        #1;
        chkInt("u2 rstX", int'(dx2), 19);
        chkInt("u2 rstY", int'(dy2), 14);
        chkInt("u2 rstSync", int'({hs2, vs2, bl2, ls2, fs2}), 5'b11000);
        chkInt("u2 rstFc", int'(fc2), 0);
        repeat (2) @(posedge Clk);
        #1;
        rst2 = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        chkInt("u2 restartXY", int'({dx2, dy2}), 0);
        chkInt("u2 restartStrobes", int'({ls2, fs2, bl2}), 3'b111);
        chkInt("u2 restartFc", int'(fc2), 0);
        for (int r = 0; r < 12; r++) begin
          repeat ($urandom_range(2000, 30)) @(posedge Clk);
          #($urandom_range(8, 1));
          rst2 = 1'b1;
          repeat ($urandom_range(3, 1)) @(posedge Clk);
          #1;
          rst2 = 1'b0;
        end
      end
      begin : wrapSeq
        int n;
        for (n = 0; n < 60000 && fc1 != 8'hFF; n++) @(negedge Clk);
        chkInt("u1 reach255", int'(fc1), 255);
        for (n = 0; n < 400 && fc1 == 8'hFF; n++) @(negedge Clk);
        chkInt("u1 wrapTo0", int'(fc1), 0);
        chkInt("u1 wrapRow", int'(dy1), 8);
        repeat (400) @(negedge Clk);
      end
    join

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Generates 640x480@60 VGA raster timing from the 50 MHz system clock using a pixel clock-enable rather than a derived clock. Drives DrawX/DrawY into the background region decoder and sprite/colour logic, and drives hs/vs/blank_n to the DAC. Also provides frame/line strobes and a frame counter for game-tick logic.

Parameters:
H_VISIBLE, 640, active pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_VISIBLE, 480, active lines
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BACK, 33, vertical back porch (lines)
CLK_DIV, 2, Clk cycles per pixel (>=1)

Ports:
Clk  in  1  system clock; the block's only clock
Reset  in  1  asynchronous, active-high reset
pixel_ce  out  1  pixel clock-enable, high one Clk cycle in every CLK_DIV
DrawX  out  10  current pixel column, 0..H_TOTAL-1
DrawY  out  10  current line, 0..V_TOTAL-1
hs  out  1  horizontal sync, active low
vs  out  1  vertical sync, active low
blank_n  out  1  1 = visible pixel, 0 = blanking
line_start  out  1  one-Clk strobe after DrawX becomes 0
frame_start  out  1  one-Clk strobe after (DrawX,DrawY) becomes (0,0)
frame_count  out  8  completed-frame counter, wraps 255->0

Behaviour:
- Reset is asynchronous, active-high. Clk is the only clock.
- Derived constants: H_TOTAL = sum of the H_* parameters (800); V_TOTAL = sum of the V_* parameters (525). Both totals must be <= 1024. Counters and arithmetic are 10-bit unsigned.
- Divider: div counts 0..CLK_DIV-1 and resets to 0. pixel_ce = (div == CLK_DIV-1), decoded combinationally from div. With CLK_DIV=1, pixel_ce is constantly 1 once Reset is low.
- Raster counters: update only at a Clk edge where pixel_ce = 1.
  - DrawX increments. At H_TOTAL-1 it wraps to 0.
  - On the DrawX wrap, DrawY increments. At V_TOTAL-1 it wraps to 0.
- Reset values:
  - DrawX = H_TOTAL-1 (799), DrawY = V_TOTAL-1 (524)
  - hs = 1, vs = 1, blank_n = 0
  - line_start = 0, frame_start = 0, frame_count = 0, div = 0
  - The first pixel_ce after Reset deasserts therefore lands on (0,0) and fires both strobes.
- hs, vs and blank_n are registered. They are computed from the next counter values, so they are cycle-aligned with DrawX/DrawY (zero relative latency).
  - hs = 0 iff H_VISIBLE+H_FRONT <= DrawX <= H_VISIBLE+H_FRONT+H_SYNC-1 (656..751).
  - vs = 0 iff V_VISIBLE+V_FRONT <= DrawY <= V_VISIBLE+V_FRONT+V_SYNC-1 (490..491).
  - blank_n = 1 iff DrawX < H_VISIBLE and DrawY < V_VISIBLE.
- line_start / frame_start:
  - Registered, high for exactly one Clk cycle: the cycle immediately after the edge where DrawX (respectively DrawX and DrawY) became 0.
  - Never high for more than one cycle, including when CLK_DIV=1.
- frame_count:
  - Increments at the pixel_ce edge where DrawY goes from 489 to 490 (vsync entry).
  - It is therefore stable throughout each visible region.
  - The first visible frame after reset reads 0.
- Reset mid-frame: all state returns to reset values immediately (asynchronous). No partial strobes are emitted. The raster restarts at (0,0) on the next pixel_ce after Reset deasserts.
- Outputs are glitch-free registers, except pixel_ce, which is a decode of a register.

Decomposition:
- Package vga_pkg holds:
  - the default timing constants and derived H_TOTAL/V_TOTAL
  - a coord_t typedef (logic [9:0])
  - the region-code typedef shared with the background region decoder
- One sub-module, clk_en_div (parameter CLK_DIV; ports Clk, Reset, ce). The raster counters and sync decode stay in vga_timing_gen.

Test Plan:
- Reset release: outputs hold reset values (799, 524, hs=1, vs=1, blank_n=0). The first pixel_ce yields DrawX=0, DrawY=0, blank_n=1, and line_start plus frame_start each high for 1 Clk cycle.
- Line timing (CLK_DIV=2):
  - blank_n falls as DrawX goes 639->640.
  - hs falls as DrawX reaches 656 and rises at 752.
  - Line period is 1600 Clk cycles.
- Frame timing:
  - blank_n is held 0 for DrawY 480..524.
  - vs is low exactly for lines 490-491 (3200 Clk cycles).
  - frame_start period is 840000 Clk cycles.
  - frame_count steps 0->1 when DrawY reaches 490.
- Wrap: drive 256 frames (or force the count) and check frame_count goes 255->0 with no extra strobes.
- Reset mid-line at DrawX=300, DrawY=100: outputs return to reset values within the same cycle as Reset asserts. After release the raster restarts at (0,0) and frame_count=0.
- CLK_DIV=1: pixel_ce is constantly high and the line period is 800 Clk cycles. Strobes stay single-cycle and hs/vs positions are unchanged in pixel terms.
